// File: rtl/sprite_frame_ctrl.sv
// ============================================================================
// sprite_frame_ctrl: per-frame erase / move / redraw sequencer for a 16x32
// sprite on a 160x120 3-bit framebuffer. Option macro: TRANSPARENT_SKIP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_frame_ctrl #(
  parameter logic [7:0] X_INIT   = 8'd72,
  parameter logic [6:0] Y_INIT   = 7'd60,
  parameter int         STEP     = 1,
  parameter logic [2:0] BG_COLOR = 3'b111,
  parameter int         SPR_W    = 16,
  parameter int         SPR_H    = 32,
  parameter int         Y_OFS    = 9
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic [2:0] spr_color,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [7:0] yasu_x,
  output logic [6:0] yasu_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done
);

  localparam int X_MAX = 160 - SPR_W;
  localparam int Y_MAX = 120 - SPR_H + Y_OFS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] cx;
  logic [4:0] cy;
  logic       pending;
  logic [7:0] next_x;
  logic [6:0] next_y;
  logic       scan_last;
  logic       draw_plot;

  // cx/cy are zero outside the scan states, so the address stays at the box origin there.
  assign pix_x     = yasu_x + {4'd0, cx};
  assign pix_y     = yasu_y - 7'(Y_OFS) + {2'd0, cy};
  assign scan_last = (cx == 4'd15) && (cy == 5'd31);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

`ifdef TRANSPARENT_SKIP_EN
  assign draw_plot = (spr_color != BG_COLOR);
`else
  assign draw_plot = 1'b1;
`endif

  always_comb begin
    next_x = yasu_x;
    next_y = yasu_y;
    if (mv_left && !mv_right)
      next_x = (yasu_x < 8'(STEP)) ? 8'd0 : yasu_x - 8'(STEP);
    else if (mv_right && !mv_left)
      next_x = (({1'b0, yasu_x} + 9'(STEP)) > 9'(X_MAX)) ? 8'(X_MAX) : yasu_x + 8'(STEP);
    if (mv_up && !mv_down)
      next_y = ({1'b0, yasu_y} < 8'(Y_OFS + STEP)) ? 7'(Y_OFS) : yasu_y - 7'(STEP);
    else if (mv_down && !mv_up)
      next_y = (({1'b0, yasu_y} + 8'(STEP)) > 8'(Y_MAX)) ? 7'(Y_MAX) : yasu_y + 7'(STEP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cx        <= 4'd0;
      cy        <= 5'd0;
      pending   <= 1'b0;
      yasu_x    <= X_INIT;
      yasu_y    <= Y_INIT;
      vga_x     <= 8'd0;
      vga_y     <= 7'd0;
      vga_color <= 3'd0;
      vga_plot  <= 1'b0;
    end else begin
      vga_x     <= pix_x;
      vga_y     <= pix_y;
      vga_color <= (state == S_ERASE) ? BG_COLOR : spr_color;
      vga_plot  <= (state == S_ERASE) || ((state == S_DRAW) && draw_plot);

      // Only one redraw request can be queued behind the running frame.
      if (frame_tick && state != S_IDLE && state != S_DONE)
        pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            state <= S_ERASE;
            cx    <= 4'd0;
            cy    <= 5'd0;
          end
        end
        S_ERASE, S_DRAW: begin
          cx <= cx + 4'd1;
          if (cx == 4'd15)
            cy <= cy + 5'd1;
          if (scan_last)
            state <= (state == S_ERASE) ? S_UPDATE : S_DONE;
        end
        S_UPDATE: begin
          yasu_x <= next_x;
          yasu_y <= next_y;
          cx     <= 4'd0;
          cy     <= 5'd0;
          state  <= S_DRAW;
        end
        S_DONE: begin
          if (pending || frame_tick) begin
            state   <= S_ERASE;
            pending <= 1'b0;
            cx      <= 4'd0;
            cy      <= 5'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
